line_fetch_sched: RTL and testbench
===================================

# line_fetch_sched

Bus scheduler that sits between the CRTC and the shared Wishbone memory bus. It launches one burst per display line to copy the next scanline's words from the frame buffer into a two-bank line buffer. Between those bursts it passes single CPU transactions through to the same bus. Video has priority. A missed fetch deadline is flagged as an underrun.

## Interface
Parameters:
- ADDR_W, 24, word address width
- DATA_W, 16, bus and line-buffer word width
- WORDS_W, 7, width of per-line word count and line-buffer address

Ports:
- dotclk_i  in  1  dot clock; the only clock
- reset_ni  in  1  asynchronous, active-low reset
- line_start_i  in  1  one-cycle pulse on the last dot of each scanline (CRTC x == htotal)
- vfen_i  in  1  CRTC video fetch enable
- y_i  in  10  CRTC raster line counter
- fb_base_i  in  ADDR_W  frame buffer base word address
- stride_i  in  16  words between successive lines (zero-extended)
- words_i  in  WORDS_W  words fetched per line; 0 disables fetching
- lb_we_o  out  1  line-buffer write strobe
- lb_bank_o  out  1  line-buffer bank being filled
- lb_adr_o  out  WORDS_W  line-buffer word index
- lb_dat_o  out  DATA_W  line-buffer write data
- cpu_cyc_i, cpu_stb_i, cpu_we_i  in  1 each  CPU Wishbone slave controls
- cpu_adr_i  in  ADDR_W  CPU address
- cpu_dat_i  in  DATA_W  CPU write data
- cpu_dat_o  out  DATA_W  CPU read data
- cpu_ack_o  out  1  CPU acknowledge
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  master controls
- wb_adr_o  out  ADDR_W  master address
- wb_dat_o  out  DATA_W  master write data
- wb_dat_i  in  DATA_W  master read data
- wb_ack_i  in  1  master acknowledge
- busy_o  out  1  a video fetch is pending or in progress
- underrun_o  out  1  sticky underrun flag
- underrun_clr_i  in  1  clears underrun_o

## Operation
- A **fetch request** is the cycle where line_start_i & vfen_i are both high.
- **Line pointer** (line_ptr, ADDR_W):
  - Reloaded from fb_base_i on any line_start_i with vfen_i low.
  - On every fetch request, line_ptr is latched as the burst base, then line_ptr += stride_i.
  - All address arithmetic wraps modulo 2^ADDR_W.
- **Fetch request latching:**
  - The request latches bank = ~y_i[0] and sets pending.
  - If words_i == 0, pending is not set and no bus cycle occurs.
- **FSM states:** IDLE, VID, CPU.
  - IDLE → VID when pending or a fetch request is present. Video takes priority.
  - IDLE → CPU otherwise, when cpu_cyc_i & cpu_stb_i.
  - VID:
    - wb_cyc_o = wb_stb_o = 1, wb_we_o = 0, wb_adr_o = base + cnt.
    - On each wb_ack_i, cnt increments.
    - When cnt == words_i − 1 and wb_ack_i: clear pending, go to IDLE. The burst is never interrupted.
  - CPU:
    - wb_cyc/stb/we/adr/dat_o mirror the cpu_* inputs.
    - cpu_ack_o = wb_ack_i and cpu_dat_o = wb_dat_i.
    - On wb_ack_i, or if cpu_cyc_i drops, go to IDLE. Exactly one CPU transfer per grant.
  - Outside CPU state, cpu_ack_o = 0.
- **Line-buffer write:** lb_we_o = (VID & wb_ack_i), with lb_adr_o = cnt, lb_dat_o = wb_dat_i, lb_bank_o = latched bank.
- **Underrun:** a fetch request that arrives while pending or in VID:
  - sets underrun_o;
  - is dropped, with no new burst queued;
  - still advances line_ptr.
  - The current burst completes normally.
  - If underrun_clr_i coincides with a new underrun, the set wins.
- busy_o = pending | (state == VID).

## Timing
- **Reset values:** state IDLE; all wb_* outputs, cpu_ack_o, lb_we_o, busy_o and underrun_o are 0; line_ptr, cnt, bank and all data/address outputs are 0.
- Asserting reset_ni mid-burst drops wb_cyc_o immediately and discards the fetch.
- **Burst launch:** a fetch request at cycle N while in IDLE gives wb_cyc_o = 1 at N+1 with wb_adr_o = base.
  - If the request arrives while in CPU state, the burst starts the cycle after IDLE is re-entered.
- **Throughput:** one word per wb_ack_i. With zero-wait acks, a burst of W words takes W cycles; wb_cyc_o falls in cycle N+W+1.
- **Write timing:** lb_we_o and lb_dat_o are combinational in the same cycle as wb_ack_i (zero latency).
- **CPU grant:** a CPU request at cycle N from IDLE (no video pending) is granted at N+1. The request must be held until ack.
- **Address updates:** wb_adr_o in VID updates on the clock edge after each ack.

## Structure
- Shared package: FSM state encoding (IDLE, VID, CPU) and default widths ADDR_W/DATA_W/WORDS_W.
- No sub-module is required. The line-pointer accumulator may be split out as line_ptr_gen (reload, latch, add stride) if reused by a future cursor or sprite fetcher.

## Test plan
- fb_base=0x1000, stride=40, words=4, vfen high on two consecutive line_starts, zero-wait acks → bursts at adr 0x1000–0x1003 and 0x1028–0x102B; lb_adr 0..3; banks alternate per y_i[0].
- vfen low line_start then fetch request → line_ptr reloaded; burst base = fb_base.
- CPU read in flight when a fetch request arrives → CPU ack delivered first, then the video burst starts the next cycle; no underrun.
- Acks delayed 100 cycles each, words=8 → second request sets underrun_o; first burst finishes all 8 words; third burst base = fb_base + 2·stride; underrun_clr_i clears the flag.
- words=0 with vfen high → no wb_cyc_o and busy_o stays 0; CPU transfers proceed unhindered.
- reset_ni pulsed low at word 2 of a burst → wb_cyc_o low asynchronously, all outputs 0; the next request starts from base with cnt=0.

Source files
------------

// File: rtl/line_fetch_sched_pkg.sv
// line_fetch_sched_pkg: shared FSM encoding and default widths for the line fetch scheduler
package line_fetch_sched_pkg;
    localparam int DEF_ADDR_W  = 24;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_WORDS_W = 7;
    typedef enum logic [1:0] {ST_IDLE, ST_VID, ST_CPU} state_t;
endpackage

// File: rtl/line_ptr_gen.sv
// line_ptr_gen: per-scanline frame-buffer pointer (reload from base, advance by stride)
//   clk, rst_n : clock, asynchronous active-low reset
//   reload     : load ptr from base
//   advance    : add zero-extended stride to ptr (wraps modulo 2^ADDR_W)
//   ptr        : current line pointer
module line_ptr_gen
    import line_fetch_sched_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reload,
    input  logic              advance,
    input  logic [ADDR_W-1:0] base,
    input  logic [15:0]       stride,
    output logic [ADDR_W-1:0] ptr
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (reload)
            ptr <= base;
        else if (advance)
            ptr <= ptr + ADDR_W'(stride);
    end
endmodule

// File: rtl/line_fetch_sched.sv
// line_fetch_sched: arbitrates the Wishbone bus between per-line video bursts and CPU singles
//   dotclk_i, reset_ni              : dot clock, asynchronous active-low reset
//   line_start_i, vfen_i, y_i       : CRTC timing; fetch request = line_start_i & vfen_i
//   fb_base_i, stride_i, words_i    : frame buffer geometry; words_i == 0 disables fetching
//   lb_*                            : line-buffer write port (bank, index, data, strobe)
//   cpu_*                           : CPU Wishbone slave side
//   wb_*                            : shared Wishbone master side
//   busy_o, underrun_o, underrun_clr_i : fetch status and sticky underrun flag
module line_fetch_sched
    import line_fetch_sched_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int WORDS_W = DEF_WORDS_W
) (
    input  logic               dotclk_i,
    input  logic               reset_ni,
    input  logic               line_start_i,
    input  logic               vfen_i,
    input  logic [9:0]         y_i,
    input  logic [ADDR_W-1:0]  fb_base_i,
    input  logic [15:0]        stride_i,
    input  logic [WORDS_W-1:0] words_i,
    output logic               lb_we_o,
    output logic               lb_bank_o,
    output logic [WORDS_W-1:0] lb_adr_o,
    output logic [DATA_W-1:0]  lb_dat_o,
    input  logic               cpu_cyc_i,
    input  logic               cpu_stb_i,
    input  logic               cpu_we_i,
    input  logic [ADDR_W-1:0]  cpu_adr_i,
    input  logic [DATA_W-1:0]  cpu_dat_i,
    output logic [DATA_W-1:0]  cpu_dat_o,
    output logic               cpu_ack_o,
    output logic               wb_cyc_o,
    output logic               wb_stb_o,
    output logic               wb_we_o,
    output logic [ADDR_W-1:0]  wb_adr_o,
    output logic [DATA_W-1:0]  wb_dat_o,
    input  logic [DATA_W-1:0]  wb_dat_i,
    input  logic               wb_ack_i,
    output logic               busy_o,
    output logic               underrun_o,
    input  logic               underrun_clr_i
);
    state_t             state, state_nx;
    logic [ADDR_W-1:0]  line_ptr, base;
    logic [WORDS_W-1:0] cnt;
    logic               bank, pending;
    logic               req, accept, overrun, last, vid, cpu;
    logic               unused_y;

    assign unused_y = ^y_i[9:1];
    assign vid      = state == ST_VID;
    assign cpu      = state == ST_CPU;
    assign req      = line_start_i & vfen_i;
    // a request is only queued when no burst is outstanding; otherwise it is an underrun
    assign accept   = req & ~pending & ~vid & (words_i != '0);
    assign overrun  = req & (pending | vid);
    assign last     = vid & wb_ack_i & (cnt == words_i - WORDS_W'(1));

    line_ptr_gen #(.ADDR_W(ADDR_W)) u_line_ptr (
        .clk    (dotclk_i),
        .rst_n  (reset_ni),
        .reload (line_start_i & ~vfen_i),
        .advance(req),
        .base   (fb_base_i),
        .stride (stride_i),
        .ptr    (line_ptr)
    );

    always_ff @(posedge dotclk_i or negedge reset_ni) begin
        if (!reset_ni)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: state_nx = (pending | accept) ? ST_VID : (cpu_cyc_i & cpu_stb_i) ? ST_CPU : ST_IDLE;
            ST_VID:  state_nx = last ? ST_IDLE : ST_VID;
            ST_CPU:  state_nx = (wb_ack_i | ~cpu_cyc_i) ? ST_IDLE : ST_CPU;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        wb_cyc_o  = vid | (cpu & cpu_cyc_i);
        wb_stb_o  = vid | (cpu & cpu_stb_i);
        wb_we_o   = cpu & cpu_we_i;
        wb_adr_o  = vid ? base + ADDR_W'(cnt) : cpu ? cpu_adr_i : '0;
        wb_dat_o  = cpu ? cpu_dat_i : '0;
        cpu_ack_o = cpu & wb_ack_i;
        cpu_dat_o = cpu ? wb_dat_i : '0;
        lb_we_o   = vid & wb_ack_i;
        lb_adr_o  = cnt;
        lb_dat_o  = (vid & wb_ack_i) ? wb_dat_i : '0;
        lb_bank_o = bank;
        busy_o    = pending | vid;
    end

    // base and bank are captured only for accepted requests so a dropped one cannot disturb a live burst
    always_ff @(posedge dotclk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            base       <= '0;
            bank       <= 1'b0;
            pending    <= 1'b0;
            cnt        <= '0;
            underrun_o <= 1'b0;
        end else begin
            if (accept) begin
                base <= line_ptr;
                bank <= ~y_i[0];
            end
            pending    <= accept | (pending & ~last);
            if (vid & wb_ack_i)
                cnt <= last ? '0 : cnt + WORDS_W'(1);
            underrun_o <= overrun | (underrun_o & ~underrun_clr_i);
        end
    end
endmodule

// File: tb/tb_line_fetch_sched.sv
// tb_line_fetch_sched: directed plus randomized checks of line_fetch_sched against a behavioural model
module tb_line_fetch_sched;
    logic        dotclk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic        line_start_i = 1'b0, vfen_i = 1'b0;
    logic [9:0]  y_i = '0;
    logic [23:0] fb_base_i = '0;
    logic [15:0] stride_i = '0;
    logic [6:0]  words_i = '0;
    logic        lb_we_o, lb_bank_o;
    logic [6:0]  lb_adr_o;
    logic [15:0] lb_dat_o;
    logic        cpu_cyc_i = 1'b0, cpu_stb_i = 1'b0, cpu_we_i = 1'b0;
    logic [23:0] cpu_adr_i = '0;
    logic [15:0] cpu_dat_i = '0;
    logic [15:0] cpu_dat_o;
    logic        cpu_ack_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [23:0] wb_adr_o;
    logic [15:0] wb_dat_o;
    logic [15:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        busy_o, underrun_o;
    logic        underrun_clr_i = 1'b0;

    line_fetch_sched dut (
        .dotclk_i(dotclk_i), .reset_ni(reset_ni), .line_start_i(line_start_i), .vfen_i(vfen_i),
        .y_i(y_i), .fb_base_i(fb_base_i), .stride_i(stride_i), .words_i(words_i),
        .lb_we_o(lb_we_o), .lb_bank_o(lb_bank_o), .lb_adr_o(lb_adr_o), .lb_dat_o(lb_dat_o),
        .cpu_cyc_i(cpu_cyc_i), .cpu_stb_i(cpu_stb_i), .cpu_we_i(cpu_we_i), .cpu_adr_i(cpu_adr_i),
        .cpu_dat_i(cpu_dat_i), .cpu_dat_o(cpu_dat_o), .cpu_ack_o(cpu_ack_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .busy_o(busy_o), .underrun_o(underrun_o), .underrun_clr_i(underrun_clr_i)
    );

    always #5 dotclk_i = ~dotclk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // behavioural model: mode 0 = bus free, 1 = video burst, 2 = CPU transfer
    int          m_st, m_done, wait_cnt, ack_delay;
    logic [23:0] m_ptr, m_base;
    bit          m_bank, m_pend, m_urun, stb_e, cpu_done;
    int          total, passed, failed, cpu_acks;
    logic [23:0] adr_log[$];
    logic [6:0]  lba_log[$];
    logic        bank_log[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [86:0] outs();
        return {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, cpu_ack_o, cpu_dat_o,
                lb_we_o, lb_bank_o, lb_adr_o, lb_dat_o, busy_o, underrun_o};
    endfunction

    function automatic logic [86:0] model_outs();
        bit vid, cpu, lbwe;
        vid  = m_st == 1;
        cpu  = m_st == 2;
        lbwe = vid && wb_ack_i;
        return {vid | (cpu & cpu_cyc_i), vid | (cpu & cpu_stb_i), cpu & cpu_we_i,
                vid ? m_base + 24'(m_done) : (cpu ? cpu_adr_i : 24'h0),
                cpu ? cpu_dat_i : 16'h0, cpu & wb_ack_i, cpu ? wb_dat_i : 16'h0,
                lbwe, m_bank, 7'(m_done), lbwe ? wb_dat_i : 16'h0, m_pend | vid, m_urun};
    endfunction

    task automatic model_reset();
        m_st = 0; m_done = 0; wait_cnt = 0;
        m_ptr = '0; m_base = '0;
        m_bank = 0; m_pend = 0; m_urun = 0; cpu_done = 0;
    endtask

    task automatic model_step();
        bit req, acc, ur;
        logic [23:0] old_ptr;
        req = line_start_i && vfen_i;
        acc = req && !m_pend && m_st != 1 && words_i != 0;
        ur  = req && (m_pend || m_st == 1);
        old_ptr = m_ptr;
        if (line_start_i && !vfen_i) m_ptr = fb_base_i;
        else if (req) m_ptr = m_ptr + {8'h0, stride_i};
        if (acc) begin
            m_base = old_ptr;
            m_bank = !y_i[0];
        end
        m_urun = ur ? 1 : (underrun_clr_i ? 0 : m_urun);
        cpu_done = 0;
        if (m_st == 0) begin
            if (m_pend || acc) m_st = 1;
            else if (cpu_cyc_i && cpu_stb_i) m_st = 2;
        end else if (m_st == 1) begin
            if (wb_ack_i) begin
                if (m_done + 1 == int'(words_i)) begin
                    m_done = 0;
                    m_pend = 0;
                    m_st = 0;
                end else m_done++;
            end
        end else if (wb_ack_i || !cpu_cyc_i) begin
            m_st = 0;
            cpu_done = 1;
        end
        if (acc) m_pend = 1;
        wait_cnt = (stb_e && !wb_ack_i) ? wait_cnt + 1 : 0;
    endtask

    task automatic cyc();
        stb_e = (m_st == 1) || (m_st == 2 && cpu_cyc_i && cpu_stb_i);
        wb_ack_i = stb_e && wait_cnt >= ack_delay;
        wb_dat_i = 16'($urandom);
        @(negedge dotclk_i);
        check("cycle", outs(), model_outs());
        if (lb_we_o) begin
            adr_log.push_back(wb_adr_o);
            lba_log.push_back(lb_adr_o);
            bank_log.push_back(lb_bank_o);
        end
        if (cpu_ack_o) cpu_acks++;
        model_step();
        @(posedge dotclk_i);
        #1;
        line_start_i = 0;
        underrun_clr_i = 0;
        if (cpu_done) begin
            cpu_cyc_i = 0; cpu_stb_i = 0; cpu_we_i = 0;
        end
    endtask

    task automatic line(input int n, input bit v, input logic [9:0] y);
        line_start_i = 1; vfen_i = v; y_i = y;
        cyc();
        repeat (n - 1) cyc();
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy_o && n < limit) begin
            cyc();
            n++;
        end
        check("wait_idle", 128'(busy_o), 0);
    endtask

    task automatic cpu_start(input logic w, input logic [23:0] a, input logic [15:0] d);
        cpu_cyc_i = 1; cpu_stb_i = 1; cpu_we_i = w; cpu_adr_i = a; cpu_dat_i = d;
    endtask

    task automatic clear_logs();
        adr_log.delete(); lba_log.delete(); bank_log.delete();
    endtask

    initial begin
        model_reset();
        ack_delay = 0;
        #1;
        check("reset_outs", 128'(outs()), 0);
        #20;
        reset_ni = 1;
        @(posedge dotclk_i);
        #1;

        // two consecutive fetch lines, zero-wait acks
        fb_base_i = 24'h1000; stride_i = 40; words_i = 4;
        line(10, 0, 0);
        clear_logs();
        line(10, 1, 0);
        line(10, 1, 1);
        check("t1_count", 128'(adr_log.size()), 8);
        for (int i = 0; i < adr_log.size(); i++) begin
            check("t1_adr", 128'(adr_log[i]), 128'(24'h1000 + (i / 4) * 40 + (i % 4)));
            check("t1_lbadr", 128'(lba_log[i]), 128'(i % 4));
            check("t1_bank", 128'(bank_log[i]), 128'(i < 4));
        end

        // reload then fetch uses the new base
        fb_base_i = 24'h2000;
        line(10, 0, 5);
        clear_logs();
        line(10, 1, 2);
        check("t2_count", 128'(adr_log.size()), 4);
        if (adr_log.size() > 0) check("t2_base", 128'(adr_log[0]), 128'(24'h2000));

        // CPU read in flight when a fetch request arrives
        clear_logs();
        cpu_acks = 0;
        ack_delay = 3;
        cpu_start(0, 24'h000055, 16'h0);
        cyc();
        cyc();
        line_start_i = 1; vfen_i = 1; y_i = 4;
        cyc();
        wait_idle(100);
        check("t3_cpu_ack", 128'(cpu_acks), 1);
        check("t3_no_urun", 128'(underrun_o), 0);
        check("t3_count", 128'(adr_log.size()), 4);
        if (adr_log.size() > 0) check("t3_base", 128'(adr_log[0]), 128'(24'h2028));

        // slow acks: second request is an underrun, third uses base + 2*stride
        fb_base_i = 24'h3000; stride_i = 40; words_i = 8; ack_delay = 100;
        line(10, 0, 0);
        clear_logs();
        line(20, 1, 0);
        line_start_i = 1; vfen_i = 1; y_i = 1;
        cyc();
        check("t4_urun_set", 128'(underrun_o), 1);
        wait_idle(2000);
        check("t4_count", 128'(adr_log.size()), 8);
        for (int i = 0; i < adr_log.size(); i++) begin
            check("t4_adr", 128'(adr_log[i]), 128'(24'h3000 + i));
            check("t4_bank", 128'(bank_log[i]), 1);
        end
        check("t4_urun_held", 128'(underrun_o), 1);
        underrun_clr_i = 1;
        cyc();
        check("t4_urun_clr", 128'(underrun_o), 0);
        ack_delay = 0;
        clear_logs();
        line(12, 1, 2);
        check("t4_third_count", 128'(adr_log.size()), 8);
        if (adr_log.size() > 0) check("t4_third_base", 128'(adr_log[0]), 128'(24'h3050));

        // words = 0: no video traffic, CPU unaffected
        words_i = 0; ack_delay = 1;
        clear_logs();
        cpu_acks = 0;
        cpu_start(1, 24'h000077, 16'hBEEF);
        line(10, 1, 0);
        check("t5_busy", 128'(busy_o), 0);
        line(10, 1, 1);
        check("t5_cpu_ack", 128'(cpu_acks), 1);
        check("t5_no_video", 128'(adr_log.size()), 0);
        check("t5_busy_end", 128'(busy_o), 0);

        // reset in the middle of a burst
        fb_base_i = 24'h4000; words_i = 6; ack_delay = 0;
        line(10, 0, 0);
        line_start_i = 1; vfen_i = 1; y_i = 0;
        cyc();
        cyc();
        cyc();
        check("t6_cnt2", 128'(lb_adr_o), 2);
        reset_ni = 0;
        #1;
        check("t6_cyc_low", 128'(wb_cyc_o), 0);
        check("t6_outs_zero", 128'(outs()), 0);
        #1;
        reset_ni = 1;
        model_reset();
        cpu_cyc_i = 0; cpu_stb_i = 0; cpu_we_i = 0;
        clear_logs();
        line(10, 0, 0);
        line(10, 1, 0);
        check("t6_count", 128'(adr_log.size()), 6);
        if (adr_log.size() > 0) begin
            check("t6_base", 128'(adr_log[0]), 128'(24'h4000));
            check("t6_cnt0", 128'(lba_log[0]), 0);
        end

        // randomized traffic against the model
        for (int s = 0; s < 4; s++) begin
            wait_idle(4000);
            words_i = 7'($urandom_range(1, 8));
            ack_delay = $urandom_range(0, 3);
            stride_i = 16'($urandom);
            fb_base_i = (s == 0) ? 24'hFFFFF0 : 24'($urandom);
            for (int i = 0; i < 500; i++) begin
                line_start_i = ($urandom % 16) == 0;
                vfen_i = ($urandom % 5) != 0;
                y_i = 10'($urandom);
                underrun_clr_i = ($urandom % 40) == 0;
                if (!cpu_cyc_i && ($urandom % 6) == 0)
                    cpu_start(1'($urandom), 24'($urandom), 16'($urandom));
                else if (cpu_cyc_i && ($urandom % 64) == 0) begin
                    cpu_cyc_i = 0; cpu_stb_i = 0;
                end
                cyc();
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
